// File: rtl/rf_wr_sched_pkg.sv
// Shared constants for the register-file write scheduler.
package rf_wr_sched_pkg;

    localparam int unsigned RF_AW   = 5;
    localparam int unsigned RF_DW   = 32;
    localparam int unsigned RF_NREG = 32;

    // r0 reads as zero and is never tracked or bypassed
    localparam logic [RF_AW-1:0] R0 = '0;

    localparam int unsigned STARVE_LIMIT_DEF = 4;
    localparam int unsigned MAX_OUT_DEF      = 4;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard and outstanding-op counter for long-latency results.
module rf_scoreboard
    import rf_wr_sched_pkg::*;
#(
    parameter int unsigned MAX_OUT = MAX_OUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iss_valid,
    input  logic [RF_AW-1:0] iss_waddr,
    output logic             iss_ready,
    input  logic             b_acc,
    input  logic [RF_AW-1:0] b_waddr,
    input  logic [RF_AW-1:0] raddr1,
    input  logic [RF_AW-1:0] raddr2,
    output logic             busy1,
    output logic             busy2
);

    localparam int unsigned CW = $clog2(MAX_OUT + 1);

    logic [RF_NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               iss_acc;

    // Issue acceptance and read-side busy lookup; a completing write resolves busy
    always_comb begin
        iss_ready = (cnt_q != CW'(MAX_OUT));
        iss_acc   = iss_valid & iss_ready;
        busy1     = busy_q[raddr1] & ~(b_acc & (b_waddr == raddr1));
        busy2     = busy_q[raddr2] & ~(b_acc & (b_waddr == raddr2));
    end

    // Next scoreboard/count; a same-cycle set beats a clear
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (b_acc && (b_waddr != R0)) begin
            busy_d[b_waddr] = 1'b0;
        end
        if (iss_acc && (iss_waddr != R0)) begin
            busy_d[iss_waddr] = 1'b1;
        end
        if (iss_acc && !b_acc) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!iss_acc && b_acc && (cnt_q != '0)) begin
            // untracked results after a reset must not wrap the count
            cnt_d = cnt_q - CW'(1);
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/rf_wr_sched.sv
// Write-port arbiter between the WB stage and a long-latency unit, with bypass.
module rf_wr_sched
    import rf_wr_sched_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int unsigned MAX_OUT      = MAX_OUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_we,
    input  logic [RF_AW-1:0] a_waddr,
    input  logic [RF_DW-1:0] a_wdata,
    output logic             a_stall,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [RF_AW-1:0] b_waddr,
    input  logic [RF_DW-1:0] b_wdata,
    input  logic             iss_valid,
    input  logic [RF_AW-1:0] iss_waddr,
    output logic             iss_ready,
    input  logic [RF_AW-1:0] raddr1,
    input  logic [RF_AW-1:0] raddr2,
    output logic             busy1,
    output logic             busy2,
    output logic             fwd1_hit,
    output logic [RF_DW-1:0] fwd1_data,
    output logic             fwd2_hit,
    output logic [RF_DW-1:0] fwd2_data,
    output logic             rf_we,
    output logic [RF_AW-1:0] rf_waddr,
    output logic [RF_DW-1:0] rf_wdata
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_q, starve_d;
    logic          force_b_q, force_b_d;
    logic          b_acc;

    // Port arbitration, write mux and same-cycle bypass
    always_comb begin
        b_ready   = b_valid & (force_b_q | ~a_we);
        a_stall   = b_valid & force_b_q;
        b_acc     = b_valid & b_ready;
        rf_we     = b_acc | (a_we & ~a_stall);
        rf_waddr  = b_acc ? b_waddr : a_waddr;
        rf_wdata  = b_acc ? b_wdata : a_wdata;
        fwd1_hit  = rf_we & (rf_waddr == raddr1) & (raddr1 != R0);
        fwd2_hit  = rf_we & (rf_waddr == raddr2) & (raddr2 != R0);
        fwd1_data = rf_wdata;
        fwd2_data = rf_wdata;
    end

    // Starvation tracking: B is forced once it has waited STARVE_LIMIT cycles
    always_comb begin
        starve_d  = starve_q;
        force_b_d = force_b_q;
        if (!b_valid || b_acc) begin
            starve_d  = '0;
            force_b_d = 1'b0;
        end else begin
            if (starve_q != SW'(STARVE_LIMIT)) begin
                starve_d = starve_q + SW'(1);
            end
            if (starve_d == SW'(STARVE_LIMIT)) begin
                force_b_d = 1'b1;
            end
        end
    end

    // Arbitration state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q  <= '0;
            force_b_q <= 1'b0;
        end else begin
            starve_q  <= starve_d;
            force_b_q <= force_b_d;
        end
    end

    rf_scoreboard #(
        .MAX_OUT (MAX_OUT)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_waddr (iss_waddr),
        .iss_ready (iss_ready),
        .b_acc     (b_acc),
        .b_waddr   (b_waddr),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .busy1     (busy1),
        .busy2     (busy2)
    );

endmodule

// File: tb/tb_rf_wr_sched.sv
// Self-checking bench for rf_wr_sched: directed scenarios plus randomized traffic.
module tb_rf_wr_sched;

    localparam int STARVE_LIMIT = 4;
    localparam int MAX_OUT      = 4;

    logic        clk;
    logic        reset;
    logic        a_we;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic        a_stall;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_waddr;
    logic [31:0] b_wdata;
    logic        iss_valid;
    logic [4:0]  iss_waddr;
    logic        iss_ready;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        busy1;
    logic        busy2;
    logic        fwd1_hit;
    logic [31:0] fwd1_data;
    logic        fwd2_hit;
    logic [31:0] fwd2_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int checks;
    int failures;

    rf_wr_sched #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .MAX_OUT      (MAX_OUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .a_we      (a_we),
        .a_waddr   (a_waddr),
        .a_wdata   (a_wdata),
        .a_stall   (a_stall),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_waddr   (b_waddr),
        .b_wdata   (b_wdata),
        .iss_valid (iss_valid),
        .iss_waddr (iss_waddr),
        .iss_ready (iss_ready),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .busy1     (busy1),
        .busy2     (busy2),
        .fwd1_hit  (fwd1_hit),
        .fwd1_data (fwd1_data),
        .fwd2_hit  (fwd2_hit),
        .fwd2_data (fwd2_data),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit [31:0] mbusy;     // registers awaiting a B result
    int        mcnt;      // issued B ops not yet returned
    int        mwait;     // consecutive cycles B has been left waiting
    bit        chk_en;

    function automatic bit m_forced();
        return (mwait >= STARVE_LIMIT) && b_valid;
    endfunction

    function automatic bit m_bacc();
        return b_valid && (m_forced() || !a_we);
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model update at each clock edge from the inputs of the ending cycle
    always @(posedge clk) begin
        if (reset) begin
            mbusy  = '0;
            mcnt   = 0;
            mwait  = 0;
            chk_en = 1'b1;
        end else begin
            bit bacc;
            bit iacc;
            bacc = m_bacc();
            iacc = iss_valid && (mcnt < MAX_OUT);
            if (bacc) begin
                mwait = 0;
                if (b_waddr != 0) mbusy[b_waddr] = 1'b0;
            end else if (b_valid) begin
                mwait = mwait + 1;
            end else begin
                mwait = 0;
            end
            if (iacc && iss_waddr != 0) mbusy[iss_waddr] = 1'b1;
            if (iacc && !bacc) mcnt = mcnt + 1;
            else if (bacc && !iacc && mcnt > 0) mcnt = mcnt - 1;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            bit          e_bacc;
            bit          e_we;
            bit [4:0]    e_waddr;
            bit [31:0]   e_wdata;
            bit          e_f1;
            bit          e_f2;
            e_bacc  = m_bacc();
            e_we    = e_bacc || (a_we && !m_forced());
            e_waddr = e_bacc ? b_waddr : a_waddr;
            e_wdata = e_bacc ? b_wdata : a_wdata;
            e_f1    = e_we && (e_waddr == raddr1) && (raddr1 != 0);
            e_f2    = e_we && (e_waddr == raddr2) && (raddr2 != 0);
            cmp("m_b_ready",   32'(b_ready),   32'(e_bacc));
            cmp("m_a_stall",   32'(a_stall),   32'(m_forced()));
            cmp("m_rf_we",     32'(rf_we),     32'(e_we));
            cmp("m_iss_ready", 32'(iss_ready), 32'(mcnt != MAX_OUT));
            cmp("m_busy1",     32'(busy1),     32'(mbusy[raddr1] && !(e_bacc && b_waddr == raddr1)));
            cmp("m_busy2",     32'(busy2),     32'(mbusy[raddr2] && !(e_bacc && b_waddr == raddr2)));
            cmp("m_fwd1_hit",  32'(fwd1_hit),  32'(e_f1));
            cmp("m_fwd2_hit",  32'(fwd2_hit),  32'(e_f2));
            if (e_we) begin
                cmp("m_rf_waddr", 32'(rf_waddr), 32'(e_waddr));
                cmp("m_rf_wdata", rf_wdata, e_wdata);
            end
            if (e_f1) cmp("m_fwd1_data", fwd1_data, e_wdata);
            if (e_f2) cmp("m_fwd2_data", fwd2_data, e_wdata);
            if (!reset && iss_valid && mcnt < MAX_OUT && iss_waddr != 0 && mbusy[iss_waddr]) begin
                failures++;
                $display("FAIL stim_waw at %0t: issue to busy r%0d", $time, iss_waddr);
            end
            if (!reset && a_we && !m_forced() && a_waddr != 0 && mbusy[a_waddr]) begin
                failures++;
                $display("FAIL stim_a_busy at %0t: A write to busy r%0d", $time, a_waddr);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic zero_in();
        a_we = 1'b0; a_waddr = '0; a_wdata = '0;
        b_valid = 1'b0; b_waddr = '0; b_wdata = '0;
        iss_valid = 1'b0; iss_waddr = '0;
        raddr1 = '0; raddr2 = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic logic [4:0] pick_free();
        for (int t = 0; t < 64; t++) begin
            int r;
            r = int'($urandom_range(0, 31));
            if (!mbusy[r]) return 5'(r);
        end
        return 5'd0;
    endfunction

    function automatic logic [4:0] pick_busy();
        int q[$];
        for (int i = 0; i < 32; i++) if (mbusy[i]) q.push_back(i);
        if (q.size() == 0) return 5'($urandom_range(0, 31));
        return 5'(q[$urandom_range(0, q.size() - 1)]);
    endfunction

    int drain_regs[4] = '{1, 3, 4, 8};

    initial begin
        checks   = 0;
        failures = 0;
        chk_en   = 1'b0;
        mbusy    = '0;
        mcnt     = 0;
        mwait    = 0;
        reset    = 1'b1;
        zero_in();
        repeat (2) @(posedge clk);
        #1;
        settle();
        cmp("rst_rf_we", 32'(rf_we), 32'd0);
        cmp("rst_b_ready", 32'(b_ready), 32'd0);
        cmp("rst_a_stall", 32'(a_stall), 32'd0);
        cmp("rst_iss_ready", 32'(iss_ready), 32'd1);
        cmp("rst_busy", 32'({busy1, busy2, fwd1_hit, fwd2_hit}), 32'd0);

        // issue r5 then complete it with 0x1234
        step(); reset = 1'b0;
        iss_valid = 1'b1; iss_waddr = 5'd5; raddr1 = 5'd5;
        settle(); cmp("iss5_busy_pre", 32'(busy1), 32'd0);
        step(); iss_valid = 1'b0;
        settle(); cmp("r5_pending", 32'(busy1), 32'd1);
        step(); b_valid = 1'b1; b_waddr = 5'd5; b_wdata = 32'h1234;
        settle();
        cmp("r5_b_ready", 32'(b_ready), 32'd1);
        cmp("r5_rf_we", 32'(rf_we), 32'd1);
        cmp("r5_rf_waddr", 32'(rf_waddr), 32'd5);
        cmp("r5_fwd1_hit", 32'(fwd1_hit), 32'd1);
        cmp("r5_fwd1_data", fwd1_data, 32'h1234);
        cmp("r5_busy_resolved", 32'(busy1), 32'd0);
        step(); b_valid = 1'b0;
        settle(); cmp("r5_busy_after", 32'(busy1), 32'd0);

        // contention: A every cycle, B forced on its fifth waiting cycle
        step(); iss_valid = 1'b1; iss_waddr = 5'd6;
        step(); iss_valid = 1'b0;
        a_we = 1'b1; a_waddr = 5'd9; a_wdata = 32'hAAAA_0009;
        b_valid = 1'b1; b_waddr = 5'd6; b_wdata = 32'h0000_BEEF;
        for (int k = 0; k < STARVE_LIMIT; k++) begin
            settle();
            cmp("starve_b_ready", 32'(b_ready), 32'd0);
            cmp("starve_a_wdata", rf_wdata, 32'hAAAA_0009);
            step();
        end
        settle();
        cmp("forced_b_ready", 32'(b_ready), 32'd1);
        cmp("forced_a_stall", 32'(a_stall), 32'd1);
        cmp("forced_rf_wdata", rf_wdata, 32'h0000_BEEF);
        cmp("forced_rf_waddr", 32'(rf_waddr), 32'd6);
        step(); b_valid = 1'b0;
        settle();
        cmp("a_resume_we", 32'(rf_we), 32'd1);
        cmp("a_resume_waddr", 32'(rf_waddr), 32'd9);
        cmp("a_resume_stall", 32'(a_stall), 32'd0);

        // fill the outstanding limit with r1..r4
        step(); a_we = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            iss_valid = 1'b1; iss_waddr = 5'(i);
            settle(); cmp("fill_iss_ready", 32'(iss_ready), 32'd1);
            step();
        end
        iss_waddr = 5'd8; raddr1 = 5'd8;
        settle(); cmp("full_iss_ready", 32'(iss_ready), 32'd0);
        step(); iss_valid = 1'b0;
        settle();
        cmp("full_ignored_busy", 32'(busy1), 32'd0);
        cmp("full_still", 32'(iss_ready), 32'd0);
        b_valid = 1'b1; b_waddr = 5'd1; b_wdata = 32'h1;
        settle(); cmp("full_b_ready", 32'(b_ready), 32'd1);
        step(); b_valid = 1'b0;
        settle(); cmp("one_free", 32'(iss_ready), 32'd1);
        iss_valid = 1'b1; iss_waddr = 5'd8; b_valid = 1'b1; b_waddr = 5'd2;
        settle();
        step(); iss_valid = 1'b0; b_valid = 1'b0;
        settle(); cmp("iss_cpl_same", 32'(iss_ready), 32'd1);
        iss_valid = 1'b1; iss_waddr = 5'd1;
        settle();
        step(); iss_valid = 1'b0;
        settle(); cmp("refill_full", 32'(iss_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            b_valid = 1'b1; b_waddr = 5'(drain_regs[i]); b_wdata = 32'(i);
            settle();
            step();
        end
        b_valid = 1'b0;
        settle(); cmp("drained", 32'(iss_ready), 32'd1);

        // same-cycle set and clear of r7; B write to r0
        iss_valid = 1'b1; iss_waddr = 5'd7;
        b_valid = 1'b1; b_waddr = 5'd7; b_wdata = 32'h77; raddr2 = 5'd7; raddr1 = 5'd0;
        settle();
        step(); iss_valid = 1'b0; b_valid = 1'b0;
        settle(); cmp("r7_set_wins", 32'(busy2), 32'd1);
        b_valid = 1'b1; b_waddr = 5'd0; b_wdata = 32'hD0D0;
        settle();
        cmp("r0_rf_we", 32'(rf_we), 32'd1);
        cmp("r0_rf_waddr", 32'(rf_waddr), 32'd0);
        cmp("r0_no_fwd", 32'(fwd1_hit), 32'd0);
        step(); b_valid = 1'b0;
        settle(); cmp("r0_sb_unchanged", 32'(busy2), 32'd1);
        b_valid = 1'b1; b_waddr = 5'd7;
        step(); b_valid = 1'b0; raddr2 = 5'd0;

        // reset while B is forced and three ops are outstanding
        for (int r = 10; r <= 12; r++) begin
            iss_valid = 1'b1; iss_waddr = 5'(r);
            step();
        end
        iss_valid = 1'b0;
        a_we = 1'b1; a_waddr = 5'd13; a_wdata = 32'h1313;
        b_valid = 1'b1; b_waddr = 5'd10; b_wdata = 32'h1010; raddr1 = 5'd11;
        repeat (STARVE_LIMIT) step();
        settle(); cmp("pre_rst_forced", 32'(a_stall), 32'd1);
        reset = 1'b1;
        step(); reset = 1'b0;
        settle();
        cmp("post_rst_b_ready", 32'(b_ready), 32'd0);
        cmp("post_rst_a_stall", 32'(a_stall), 32'd0);
        cmp("post_rst_busy", 32'(busy1), 32'd0);
        cmp("post_rst_iss_ready", 32'(iss_ready), 32'd1);
        cmp("post_rst_waddr", 32'(rf_waddr), 32'd13);

        // randomized traffic
        step(); zero_in();
        for (int n = 0; n < 4000; n++) begin
            reset     = ($urandom_range(0, 299) == 0);
            a_we      = ($urandom_range(0, 9) < 6);
            a_waddr   = pick_free();
            a_wdata   = $urandom;
            b_valid   = b_valid ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 4);
            b_waddr   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : pick_busy();
            b_wdata   = $urandom;
            iss_valid = ($urandom_range(0, 9) < 3);
            iss_waddr = pick_free();
            case ($urandom_range(0, 2))
                0:       raddr1 = a_waddr;
                1:       raddr1 = b_waddr;
                default: raddr1 = pick_busy();
            endcase
            raddr2 = ($urandom_range(0, 1) == 0) ? b_waddr : 5'($urandom_range(0, 31));
            step();
        end
        zero_in();
        reset = 1'b0;
        step();
        settle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
